arb_menor: RTL and testbench

//  Shares one fn_menor comparator (32-bit A<B, signed/unsigned) between two requesters:

---
 rtl/arb_menor_pkg.sv | 20 ++
 rtl/fn_menor.sv | 24 ++
 rtl/arb_menor.sv | 111 +++++++++++
 tb/tb_arb_menor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/arb_menor_pkg.sv
// arb_menor_pkg: shared selector encodings, port indices and slot state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//   SEL_CON_SIGNO / SEL_SIN_SIGNO : fn_menor compare mode (signed / unsigned)
//   PUERTO_ALU / PUERTO_BR        : requester indices into the 2-bit port vectors
//   slot_e                        : per-port result holding state
package arb_menor_pkg;

  localparam logic SEL_CON_SIGNO = 1'b0;
  localparam logic SEL_SIN_SIGNO = 1'b1;

  localparam int PUERTO_ALU = 0;
  localparam int PUERTO_BR  = 1;

  typedef enum logic {
    VACIO = 1'b0,
    LLENO = 1'b1
  } slot_e;

endpackage

// File: rtl/fn_menor.sv
// fn_menor: 32-bit less-than comparator, signed or unsigned by selector.
// Latency: purely combinational.
// Backpressure: none.
//   a, b  : operands
//   menor : SEL_CON_SIGNO -> two's complement compare, SEL_SIN_SIGNO -> unsigned compare
//   y     : 1 when a < b under the selected interpretation
module fn_menor
  import arb_menor_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        menor,
  output logic        y
);

  always_comb begin
    if (menor == SEL_SIN_SIGNO) begin
      y = (a < b);
    end else begin
      y = ($signed(a) < $signed(b));
    end
  end

endmodule

// File: rtl/arb_menor.sv
// arb_menor: round-robin sharing of one fn_menor between ALU (port 0) and branch unit (port 1).
// Latency: request granted in cycle N -> registered result valid in cycle N+1.
// Backpressure: a result held with rsp_ready low blocks only that port; draining frees it same cycle.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid / req_ready : per-port request handshake (req_ready is the one-hot grant)
//   req_a0/b0, req_a1/b1  : operands per port; req_menor[i] selects signed(0)/unsigned(1)
//   rsp_valid / rsp_ready : per-port result handshake; rsp_y0/rsp_y1 are the results
//   cnt_conflict          : saturating count of cycles with both ports eligible
module arb_menor
  import arb_menor_pkg::*;
#(
  parameter int PRIO_INI  = 0,
  parameter int ANCHO_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [31:0]          req_a0,
  input  logic [31:0]          req_b0,
  input  logic [31:0]          req_a1,
  input  logic [31:0]          req_b1,
  input  logic [1:0]           req_menor,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic                 rsp_y0,
  output logic                 rsp_y1,
  output logic [ANCHO_CNT-1:0] cnt_conflict
);

  slot_e       slot_q [2];
  logic        prio_q;
  logic [1:0]  libre;
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic [31:0] mux_a;
  logic [31:0] mux_b;
  logic        mux_menor;
  logic        cmp_y;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rsp_valid[i] = (slot_q[i] == LLENO);
    end
  end

  // A slot draining this cycle can accept a new result at the same edge.
  assign libre = ~rsp_valid | rsp_ready;
  assign elig  = req_valid & libre;

  // Grants are suppressed during reset so no request is accepted and then lost.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (&elig) begin
        grant = prio_q ? 2'b10 : 2'b01;
      end else begin
        grant = elig;
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    mux_a     = req_a0;
    mux_b     = req_b0;
    mux_menor = req_menor[PUERTO_ALU];
    if (grant[PUERTO_BR]) begin
      mux_a     = req_a1;
      mux_b     = req_b1;
      mux_menor = req_menor[PUERTO_BR];
    end
  end

  fn_menor u_fn_menor (
    .a     (mux_a),
    .b     (mux_b),
    .menor (mux_menor),
    .y     (cmp_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q[0]    <= VACIO;
      slot_q[1]    <= VACIO;
      rsp_y0       <= 1'b0;
      rsp_y1       <= 1'b0;
      prio_q       <= 1'(PRIO_INI);
      cnt_conflict <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          slot_q[i] <= LLENO;
        end else if (rsp_ready[i]) begin
          slot_q[i] <= VACIO;
        end
      end
      if (grant[PUERTO_ALU]) rsp_y0 <= cmp_y;
      if (grant[PUERTO_BR])  rsp_y1 <= cmp_y;
      // Priority always moves to the port that was not just served.
      if (|grant) begin
        prio_q <= grant[PUERTO_ALU];
      end
      if ((&elig) && (cnt_conflict != {ANCHO_CNT{1'b1}})) begin
        cnt_conflict <= cnt_conflict + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arb_menor.sv
// tb_arb_menor: directed self-checking bench for arb_menor (PRIO_INI=0, 6-bit counter).
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low on the branch port.
module tb_arb_menor;

  localparam int W = 6;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [31:0]  a0, b0, a1, b1;
  logic [1:0]   req_menor;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic         rsp_y0, rsp_y1;
  logic [W-1:0] cnt_conflict;

  int checks = 0;
  int errors = 0;

  arb_menor #(.PRIO_INI(0), .ANCHO_CNT(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a0       (a0),
    .req_b0       (b0),
    .req_a1       (a1),
    .req_b1       (b1),
    .req_menor    (req_menor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y0       (rsp_y0),
    .rsp_y1       (rsp_y1),
    .cnt_conflict (cnt_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {a, b, menor, expected y} for back-to-back port 0 requests
  logic [31:0] va [4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] vb [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
  logic        vm [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic        vy [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11; req_menor = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // Reset held two cycles with both requests pending
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_cnt", cnt_conflict, 0);
    end

    // Port 0 alone: signed then unsigned on 0xFFFFFFFF vs 1
    rst = 1'b0; req_valid = 2'b01; a0 = 32'hFFFF_FFFF; b0 = 32'h1; req_menor = 2'b00;
    #1 chk("p0_grant_s", req_ready, 2'b01);
    tick;
    chk("p0_valid_s", rsp_valid, 2'b01);
    chk("p0_y_s", rsp_y0, 1'b1);
    req_menor = 2'b01;
    #1 chk("p0_grant_u", req_ready, 2'b01);
    tick;
    chk("p0_valid_u", rsp_valid, 2'b01);
    chk("p0_y_u", rsp_y0, 1'b0);
    req_valid = 2'b00;
    tick;
    chk("p0_drain", rsp_valid, 2'b00);

    // Contention from fresh reset: alternating grants starting at port 0
    rst = 1'b1;
    tick;
    rst = 1'b0; req_valid = 2'b11; rsp_ready = 2'b11; req_menor = 2'b00;
    a0 = 32'd5; b0 = 32'd7; a1 = 32'd7; b1 = 32'd5;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("cont_cnt", cnt_conflict, k);
      chk("cont_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick;
    end
    chk("cont_cnt_end", cnt_conflict, 6);
    chk("cont_y0", rsp_y0, 1'b1);
    chk("cont_y1", rsp_y1, 1'b0);
    chk("cont_valid", rsp_valid, 2'b10);

    // Backpressure on port 1: its held result must not be overwritten
    rsp_ready = 2'b01; a1 = 32'd1; b1 = 32'd2;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_grant", req_ready, 2'b01);
      chk("bp_valid1", rsp_valid[1], 1'b1);
      chk("bp_y1", rsp_y1, 1'b0);
      tick;
    end
    chk("bp_cnt", cnt_conflict, 6);
    rsp_ready = 2'b11;
    #1 chk("bp_release", req_ready, 2'b10);
    tick;
    chk("bp_y1_new", rsp_y1, 1'b1);
    chk("bp_valid_after", rsp_valid, 2'b10);
    chk("bp_cnt_rel", cnt_conflict, 7);
    req_valid = 2'b00;
    tick;
    chk("bp_drain", rsp_valid, 2'b00);

    // Boundary operands through port 0 at full rate
    req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      a0 = va[k]; b0 = vb[k]; req_menor = {1'b0, vm[k]};
      #1 chk("eq_grant", req_ready, 2'b01);
      tick;
      chk("eq_y", rsp_y0, vy[k]);
      chk("eq_valid", rsp_valid, 2'b01);
    end
    req_valid = 2'b00;
    tick;

    // Fill both slots, then reset discards them and restores priority
    rsp_ready = 2'b00; req_valid = 2'b11;
    #1 chk("fill_grant1", req_ready, 2'b10);
    tick;
    chk("fill_grant0", req_ready, 2'b01);
    tick;
    chk("fill_valid", rsp_valid, 2'b11);
    chk("fill_blocked", req_ready, 2'b00);
    chk("fill_cnt", cnt_conflict, 8);
    rst = 1'b1;
    tick;
    rst = 1'b0; rsp_ready = 2'b11;
    chk("rst_mid_valid", rsp_valid, 2'b00);
    chk("rst_mid_cnt", cnt_conflict, 0);
    #1 chk("rst_mid_prio", req_ready, 2'b01);

    // Saturation of the conflict counter
    for (int k = 0; k < 61; k++) tick;
    chk("sat_pre", cnt_conflict, 61);
    for (int k = 0; k < 3; k++) tick;
    chk("sat_hold", cnt_conflict, 63);
    tick;
    chk("sat_hold2", cnt_conflict, 63);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
